pipeline_ctrl: RTL and testbench

//  Central pipeline motion controller for the pipelined MIPS datapath. Generates per-latch

---
 rtl/pipeline_ctrl_pkg.sv | 25 ++
 rtl/pipeline_ctrl_if.sv | 43 ++++
 rtl/pipeline_ctrl_sat_counter.sv | 45 ++++
 rtl/pipeline_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl_pkg
//  Description : Shared types and default constants for the pipeline motion
//                controller (state encoding, latch count, MEM latch index,
//                performance counter width).
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

  localparam int unsigned c_NLATCH  = 4;
  localparam int unsigned c_MEM_LAT = 2;
  localparam int unsigned c_CNT_W   = 32;

  // RUN    : normal issue
  // DRAIN  : HALT accepted in decode, no new fetches, older work completes
  // HALTED : HALT reached the last latch, pipeline frozen until reset
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pipe_state_t;

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl_if
//  Description : Bundle between the pipeline controller and the datapath.
//                Inputs to the controller: ihit, dmem_req, dhit, use_stall,
//                redirect, halt_dec.
//                Outputs from the controller: pc_en, lat_wen, lat_flush,
//                lat_valid, halt, stall_cnt, flush_cnt.
//                master = controller side, slave = datapath side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_ctrl_if #(
  parameter int unsigned NLATCH = 4,
  parameter int unsigned CNT_W  = 32
);

  logic              ihit;
  logic              dmem_req;
  logic              dhit;
  logic              use_stall;
  logic              redirect;
  logic              halt_dec;

  logic              pc_en;
  logic [NLATCH-1:0] lat_wen;
  logic [NLATCH-1:0] lat_flush;
  logic [NLATCH-1:0] lat_valid;
  logic              halt;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    input  ihit, dmem_req, dhit, use_stall, redirect, halt_dec,
    output pc_en, lat_wen, lat_flush, lat_valid, halt, stall_cnt, flush_cnt
  );

  modport slave (
    output ihit, dmem_req, dhit, use_stall, redirect, halt_dec,
    input  pc_en, lat_wen, lat_flush, lat_valid, halt, stall_cnt, flush_cnt
  );

endinterface
`default_nettype wire

// File: rtl/pipeline_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl_sat_counter
//  Description : Saturating up-counter. Sticks at all-ones, never wraps.
//  Ports       : CLK   in  clock
//                nRST  in  asynchronous active-low reset (count -> 0)
//                inc   in  increment request
//                clear in  synchronous clear (wins over inc)
//                count out current count
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl
//  Description : Pipeline motion controller. Derives PC enable and per-latch
//                write-enable / flush from fetch and data waits, load-use
//                hazards and decode redirects; tracks per-latch valid bits and
//                a HALT token to drain the pipe; keeps saturating stall and
//                redirect counters.
//  Ports       : CLK   in   clock
//                nRST  in   asynchronous active-low reset
//                bus   master side of pipeline_ctrl_if (hazard/cache inputs,
//                      PC/latch controls, status and counters out)
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned NLATCH  = c_NLATCH,
  parameter int unsigned MEM_LAT = c_MEM_LAT,
  parameter int unsigned CNT_W   = c_CNT_W
) (
  input  logic            CLK,
  input  logic            nRST,
  pipeline_ctrl_if.master bus
);

  // Latch 1 is the IF/ID -> ID/EX boundary where decode results land.
  localparam int unsigned c_DEC_LAT = 1;

  // Elaboration-time sanity on the geometry.
  if ((MEM_LAT >= NLATCH) || (NLATCH < 2)) begin : g_geom_chk
    $error("pipeline_ctrl: MEM_LAT must index an existing latch and NLATCH >= 2");
  end

  pipe_state_t       state_q, state_d;
  logic [NLATCH-1:0] valid_q, valid_d;
  logic [NLATCH-1:0] tok_q,   tok_d;

  logic              w_mem_stall;
  logic              w_fetch_stall;
  logic              w_pc_en;
  logic [NLATCH-1:0] w_wen;
  logic [NLATCH-1:0] w_flush;
  logic              w_halt_acc;
  logic [NLATCH-1:0] w_src_valid;
  logic [NLATCH-1:0] w_src_tok;
  logic              w_stall_inc;
  logic              w_flush_inc;

  assign w_mem_stall   = bus.dmem_req & ~bus.dhit;
  assign w_fetch_stall = ~bus.ihit;

  // --------------------------------------------------------------------------
  // Latch / PC control. While reset is held every latch is forced to load a
  // bubble so the datapath registers clear alongside the controller.
  // --------------------------------------------------------------------------
  always_comb begin
    w_pc_en = 1'b0;
    w_wen   = '1;
    w_flush = '0;
    if (!nRST) begin
      w_flush = '1;
    end else begin
      case (state_q)
        RUN: begin
          if (w_mem_stall) begin
            w_wen = '0;
          end else if (bus.use_stall) begin
            // Hold fetch/decode, drop a bubble into EX, let older work go.
            w_wen[0]         = 1'b0;
            w_flush[c_DEC_LAT] = 1'b1;
          end else if (bus.redirect) begin
            // PC takes the target even if the wrong-path fetch is pending.
            w_pc_en    = 1'b1;
            w_flush[0] = 1'b1;
          end else if (w_fetch_stall) begin
            w_flush[0] = 1'b1;
          end else begin
            w_pc_en = 1'b1;
          end
        end
        DRAIN: begin
          if (w_mem_stall) begin
            w_wen = '0;
          end else begin
            w_flush[0] = 1'b1;
          end
        end
        default: begin
          w_wen = '0;
        end
      endcase
    end
  end

  // HALT is taken only when decode actually moves into the next latch.
  assign w_halt_acc = (state_q == RUN) & bus.halt_dec
                    & w_wen[c_DEC_LAT] & ~w_flush[c_DEC_LAT];

  // --------------------------------------------------------------------------
  // Valid and HALT-token shift registers, one slice per latch.
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < NLATCH; k++) begin : g_lat
    if (k == 0) begin : g_head
      assign w_src_valid[k] = bus.ihit;
      assign w_src_tok[k]   = 1'b0;
    end else if (k == c_DEC_LAT) begin : g_dec
      assign w_src_valid[k] = valid_q[k-1];
      assign w_src_tok[k]   = w_halt_acc;
    end else begin : g_body
      assign w_src_valid[k] = valid_q[k-1];
      assign w_src_tok[k]   = tok_q[k-1];
    end

    assign valid_d[k] = w_wen[k] ? (~w_flush[k] & w_src_valid[k]) : valid_q[k];
    assign tok_d[k]   = w_wen[k] ? (~w_flush[k] & w_src_tok[k])   : tok_q[k];
  end

  // --------------------------------------------------------------------------
  // State machine. HALTED is entered on the same edge the token lands in the
  // last latch, so the HALT instruction is frozen in write-back.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (w_halt_acc) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (tok_d[NLATCH-1]) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      valid_q <= '0;
      tok_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      tok_q   <= tok_d;
    end
  end

  // --------------------------------------------------------------------------
  // Performance counters. Stall cycles count any raw wait condition; flushes
  // count only redirects that were actually honoured.
  // --------------------------------------------------------------------------
  assign w_stall_inc = (state_q != HALTED)
                     & (w_mem_stall | bus.use_stall | w_fetch_stall);
  assign w_flush_inc = (state_q == RUN) & bus.redirect
                     & ~w_mem_stall & ~bus.use_stall;

  pipeline_ctrl_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (w_stall_inc),
    .clear (1'b0),
    .count (bus.stall_cnt)
  );

  pipeline_ctrl_sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (w_flush_inc),
    .clear (1'b0),
    .count (bus.flush_cnt)
  );

  assign bus.pc_en     = w_pc_en;
  assign bus.lat_wen   = w_wen;
  assign bus.lat_flush = w_flush;
  assign bus.lat_valid = valid_q;
  assign bus.halt      = (state_q == HALTED);

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_ctrl
//  Description : Self-checking bench for pipeline_ctrl. A behavioural model
//                predicts each cycle's outputs into a queue when inputs are
//                driven; entries are popped and compared at the falling edge.
//                A second instance with 3-bit counters exercises saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

  localparam int c_RUN    = 0;
  localparam int c_DRAIN  = 1;
  localparam int c_HALTED = 2;

  typedef struct packed {
    logic        pc_en;
    logic [3:0]  wen;
    logic [3:0]  flush;
    logic [3:0]  valid;
    logic        halt;
    logic [31:0] scnt;
    logic [31:0] fcnt;
    logic [2:0]  sscnt;
  } exp_t;

  logic CLK;
  logic nRST;
  logic ihit, dmem_req, dhit, use_stall, redirect, halt_dec;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t exp_q[$];
  exp_t last;

  // model state
  int          m_state;
  logic [3:0]  m_valid;
  logic [3:0]  m_tok;
  logic [31:0] m_scnt;
  logic [31:0] m_fcnt;
  logic [2:0]  m_sscnt;

  pipeline_ctrl_if #(.NLATCH(4), .CNT_W(32)) bus   ();
  pipeline_ctrl_if #(.NLATCH(4), .CNT_W(3))  bus_s ();

  assign bus.ihit        = ihit;
  assign bus.dmem_req    = dmem_req;
  assign bus.dhit        = dhit;
  assign bus.use_stall   = use_stall;
  assign bus.redirect    = redirect;
  assign bus.halt_dec    = halt_dec;
  assign bus_s.ihit      = ihit;
  assign bus_s.dmem_req  = dmem_req;
  assign bus_s.dhit      = dhit;
  assign bus_s.use_stall = use_stall;
  assign bus_s.redirect  = redirect;
  assign bus_s.halt_dec  = halt_dec;

  pipeline_ctrl #(.NLATCH(4), .MEM_LAT(2), .CNT_W(32)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  pipeline_ctrl #(.NLATCH(4), .MEM_LAT(2), .CNT_W(3)) dut_sat (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus_s)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = c_RUN;
    m_valid = '0;
    m_tok   = '0;
    m_scnt  = '0;
    m_fcnt  = '0;
    m_sscnt = '0;
  endtask

  // Expected outputs for the current model state and driven inputs.
  task automatic model_outputs(output exp_t e);
    logic ms;
    ms      = dmem_req & ~dhit;
    e.pc_en = 1'b0;
    e.wen   = 4'hF;
    e.flush = 4'h0;
    e.valid = m_valid;
    e.halt  = (m_state == c_HALTED);
    e.scnt  = m_scnt;
    e.fcnt  = m_fcnt;
    e.sscnt = m_sscnt;
    if (!nRST) begin
      e.flush = 4'hF;
      e.halt  = 1'b0;
    end else if (m_state == c_HALTED) begin
      e.wen = 4'h0;
    end else if (ms) begin
      e.wen = 4'h0;
    end else if (m_state == c_DRAIN) begin
      e.flush = 4'b0001;
    end else if (use_stall) begin
      e.wen   = 4'b1110;
      e.flush = 4'b0010;
    end else if (redirect) begin
      e.pc_en = 1'b1;
      e.flush = 4'b0001;
    end else if (!ihit) begin
      e.flush = 4'b0001;
    end else begin
      e.pc_en = 1'b1;
    end
  endtask

  // Clock-edge update of the model using the controls it predicted.
  task automatic model_advance(input exp_t e);
    logic       ms, acc, sv, st;
    logic [3:0] nv, nt;
    ms  = dmem_req & ~dhit;
    acc = (m_state == c_RUN) && halt_dec && e.wen[1] && !e.flush[1];
    nv  = m_valid;
    nt  = m_tok;
    for (int k = 0; k < 4; k++) begin
      sv = (k == 0) ? ihit : m_valid[k-1];
      st = (k == 0) ? 1'b0 : ((k == 1) ? acc : m_tok[k-1]);
      if (e.wen[k]) begin
        nv[k] = !e.flush[k] && sv;
        nt[k] = !e.flush[k] && st;
      end
    end
    if ((m_state != c_HALTED) && (ms || use_stall || !ihit)) begin
      if (m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
      if (m_sscnt != 3'd7) m_sscnt = m_sscnt + 3'd1;
    end
    if ((m_state == c_RUN) && redirect && !ms && !use_stall) begin
      if (m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 1;
    end
    if ((m_state == c_RUN) && acc) m_state = c_DRAIN;
    else if ((m_state == c_DRAIN) && nt[3]) m_state = c_HALTED;
    m_valid = nv;
    m_tok   = nt;
  endtask

  task automatic sample_and_compare(input string ph);
    exp_t e, got;
    got.pc_en = bus.pc_en;
    got.wen   = bus.lat_wen;
    got.flush = bus.lat_flush;
    got.valid = bus.lat_valid;
    got.halt  = bus.halt;
    got.scnt  = bus.stall_cnt;
    got.fcnt  = bus.flush_cnt;
    got.sscnt = bus_s.stall_cnt;
    e = exp_q.pop_front();
    chk({ph, " pc_en"},     {31'd0, got.pc_en}, {31'd0, e.pc_en});
    chk({ph, " lat_wen"},   {28'd0, got.wen},   {28'd0, e.wen});
    chk({ph, " lat_flush"}, {28'd0, got.flush}, {28'd0, e.flush});
    chk({ph, " lat_valid"}, {28'd0, got.valid}, {28'd0, e.valid});
    chk({ph, " halt"},      {31'd0, got.halt},  {31'd0, e.halt});
    chk({ph, " stall_cnt"}, got.scnt, e.scnt);
    chk({ph, " flush_cnt"}, got.fcnt, e.fcnt);
    chk({ph, " sat_stall"}, {29'd0, got.sscnt}, {29'd0, e.sscnt});
    last = got;
  endtask

  // One clock cycle: drive at posedge+1, compare at negedge, advance model.
  task automatic step(input string ph, input logic ih, input logic dr, input logic dh,
                      input logic us, input logic rd, input logic hd);
    exp_t e;
    ihit = ih; dmem_req = dr; dhit = dh; use_stall = us; redirect = rd; halt_dec = hd;
    model_outputs(e);
    exp_q.push_back(e);
    @(negedge CLK);
    sample_and_compare(ph);
    model_advance(e);
    @(posedge CLK);
    #1;
  endtask

  // Asynchronous reset pulse starting mid-cycle; released at posedge+1.
  task automatic reset_pulse(input string ph);
    exp_t e;
    nRST = 1'b0;
    model_reset();
    #2;
    model_outputs(e);
    exp_q.push_back(e);
    sample_and_compare(ph);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  logic [31:0] scnt_at_halt;

  initial begin
    nRST = 1'b0;
    ihit = 1'b0; dmem_req = 1'b0; dhit = 1'b0;
    use_stall = 1'b0; redirect = 1'b0; halt_dec = 1'b0;
    model_reset();
    @(posedge CLK);
    #1;
    reset_pulse("reset");
    chk("reset lat_wen all ones", {28'd0, last.wen}, 32'hF);
    chk("reset lat_flush all ones", {28'd0, last.flush}, 32'hF);

    // 1: straight-line fetch
    for (int i = 0; i < 6; i++) begin
      step("t1", 1, 0, 0, 0, 0, 0);
      chk("t1 pc_en high", {31'd0, last.pc_en}, 32'd1);
      if (i == 4) chk("t1 valid full by cycle 4", {28'd0, last.valid}, 32'hF);
    end

    // 2: data miss freezes everything
    for (int i = 0; i < 3; i++) begin
      step("t2", 1, 1, 0, 0, 0, 0);
      chk("t2 frozen wen", {28'd0, last.wen}, 32'd0);
      chk("t2 frozen pc_en", {31'd0, last.pc_en}, 32'd0);
    end
    step("t2 hit", 1, 1, 1, 0, 0, 0);
    chk("t2 stall_cnt 3", last.scnt, 32'd3);
    chk("t2 valid held", {28'd0, last.valid}, 32'hF);

    // 3: load-use bubble
    step("t3", 1, 0, 0, 1, 0, 0);
    chk("t3 wen 1110", {28'd0, last.wen}, 32'hE);
    chk("t3 flush[1]", {31'd0, last.flush[1]}, 32'd1);
    step("t3 next", 1, 0, 0, 0, 0, 0);
    chk("t3 valid[1] bubble", {31'd0, last.valid[1]}, 32'd0);

    // 4: redirect with pending fetch, then redirect under data miss
    step("t4", 0, 0, 0, 0, 1, 0);
    chk("t4 redirect pc_en", {31'd0, last.pc_en}, 32'd1);
    chk("t4 redirect flush[0]", {31'd0, last.flush[0]}, 32'd1);
    step("t4 next", 1, 0, 0, 0, 0, 0);
    chk("t4 flush_cnt 1", last.fcnt, 32'd1);
    step("t4 memstall", 1, 1, 0, 0, 1, 0);
    chk("t4 ignored pc_en", {31'd0, last.pc_en}, 32'd0);
    step("t4 after", 1, 0, 0, 0, 0, 0);
    chk("t4 flush_cnt still 1", last.fcnt, 32'd1);

    // mixed random traffic, no HALT
    for (int i = 0; i < 40; i++) begin
      step("rand", ($urandom_range(3) != 0), ($urandom_range(2) == 0), $urandom_range(1),
           ($urandom_range(4) == 0), ($urandom_range(5) == 0), 1'b0);
    end
    repeat (4) step("refill", 1, 0, 0, 0, 0, 0);

    // 5: HALT drain
    step("t5 accept", 1, 0, 0, 0, 0, 1);
    step("t5 t+1", 1, 0, 0, 0, 0, 0);
    chk("t5 t+1 pc_en off", {31'd0, last.pc_en}, 32'd0);
    chk("t5 t+1 halt low", {31'd0, last.halt}, 32'd0);
    step("t5 t+2", 1, 0, 0, 0, 0, 0);
    chk("t5 t+2 halt low", {31'd0, last.halt}, 32'd0);
    step("t5 t+3", 1, 0, 0, 0, 0, 0);
    chk("t5 t+3 halt high", {31'd0, last.halt}, 32'd1);
    chk("t5 t+3 wen off", {28'd0, last.wen}, 32'd0);
    scnt_at_halt = last.scnt;
    repeat (3) step("t5 halted", 0, 1, 0, 1, 1, 1);
    chk("t5 halt sticky", {31'd0, last.halt}, 32'd1);
    chk("t5 stall_cnt frozen", last.scnt, scnt_at_halt);

    // 6: reset mid-DRAIN, then saturation of the 3-bit counter
    reset_pulse("t6 reset");
    step("t6 run", 1, 0, 0, 0, 0, 0);
    step("t6 run", 1, 0, 0, 0, 0, 0);
    step("t6 accept", 1, 0, 0, 0, 0, 1);
    step("t6 drain", 1, 0, 0, 0, 0, 0);
    chk("t6 in drain pc_en off", {31'd0, last.pc_en}, 32'd0);
    reset_pulse("t6 mid-drain reset");
    chk("t6 reset halt low", {31'd0, last.halt}, 32'd0);
    chk("t6 reset flush_cnt 0", last.fcnt, 32'd0);
    step("t6 back to run", 1, 0, 0, 0, 0, 0);
    chk("t6 run pc_en", {31'd0, last.pc_en}, 32'd1);
    repeat (9) step("t6 stall", 0, 0, 0, 0, 0, 0);
    step("t6 done", 1, 0, 0, 0, 0, 0);
    chk("t6 sat stall_cnt 7", {29'd0, last.sscnt}, 32'd7);
    chk("t6 wide stall_cnt 9", last.scnt, 32'd9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
